fetch_unit: RTL and testbench

Instruction-fetch stage sitting directly upstream of the decode stage. Owns the architectural fetch PC, issues word reads to instruction memory over a valid/ready request channel with in-order responses, and buffers returned instructions with their PCs in a small queue. Presents them to decode on a valid/ready pair. Applies branch redirects from decode's PC-source signal by flushing the queue and discarding responses still in flight.

---
 rtl/fetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_unit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding decode.
// Owns the fetch PC and issues word reads to instruction memory over a
// valid/ready request channel. Responses come back in order and always
// accepted. They are buffered with their PCs in a small queue that is
// presented to decode. A decode redirect flushes the queue and marks every
// response still in flight as stale.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   i_PC_Src              redirect strobe from decode
//   i_Branch_Target       redirect address (bits [1:0] ignored)
//   o_Mem_Req_Valid       fetch request valid
//   o_Mem_Req_Address     word-aligned fetch address
//   i_Mem_Req_Ready       memory accepts the request this cycle
//   i_Mem_Resp_Valid      in-order read response
//   i_Mem_Resp_Data       instruction word
//   o_Valid               queue head valid toward decode
//   o_Instruction, o_PC   queue head instruction and its address
//   i_Ready               decode consumes the head this cycle
module fetch_unit #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned           QUEUE_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_PC_Src,
  input  logic [DATA_WIDTH-1:0] i_Branch_Target,
  output logic                  o_Mem_Req_Valid,
  output logic [DATA_WIDTH-1:0] o_Mem_Req_Address,
  input  logic                  i_Mem_Req_Ready,
  input  logic                  i_Mem_Resp_Valid,
  input  logic [DATA_WIDTH-1:0] i_Mem_Resp_Data,
  output logic                  o_Valid,
  output logic [DATA_WIDTH-1:0] o_Instruction,
  output logic [DATA_WIDTH-1:0] o_PC,
  input  logic                  i_Ready
);

  localparam int unsigned PW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_fetch_pc;
  logic [DATA_WIDTH-1:0] r_q_pc    [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0] r_q_instr [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0] r_tag     [QUEUE_DEPTH];
  logic [PW-1:0]         r_q_rd;
  logic [PW-1:0]         r_q_wr;
  logic [PW-1:0]         r_tag_rd;
  logic [PW-1:0]         r_tag_wr;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         r_outstanding;
  logic [CW-1:0]         r_discard;

  logic [CW:0]           w_credit_used;
  logic                  w_req_fire;
  logic                  w_resp_fire;
  logic                  w_drop;
  logic                  w_push;
  logic                  w_pop;
  logic [1:0]            w_unused_tgt;

  assign w_unused_tgt = i_Branch_Target[1:0];

  // Queue entries plus in-flight requests never exceed the queue depth, so
  // every response is guaranteed a slot when it arrives.
  assign w_credit_used     = {1'b0, r_count} + {1'b0, r_outstanding};
  assign o_Mem_Req_Valid   = (r_state == ST_RUN) & ~i_PC_Src &
                             (w_credit_used < (CW+1)'(QUEUE_DEPTH));
  assign o_Mem_Req_Address = r_fetch_pc;

  assign w_req_fire  = o_Mem_Req_Valid & i_Mem_Req_Ready;
  assign w_resp_fire = i_Mem_Resp_Valid & (r_outstanding != '0);
  assign w_drop      = (r_discard != '0);
  assign w_push      = w_resp_fire & ~w_drop & ~i_PC_Src;
  assign w_pop       = o_Valid & i_Ready & ~i_PC_Src;

  assign o_Valid       = (r_count != '0);
  assign o_Instruction = r_q_instr[r_q_rd];
  assign o_PC          = r_q_pc[r_q_rd];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_fetch_pc    <= RESET_PC;
      r_q_rd        <= '0;
      r_q_wr        <= '0;
      r_tag_rd      <= '0;
      r_tag_wr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_state       <= ST_RUN;
      r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_resp_fire);
      if (w_req_fire)  r_tag_wr <= r_tag_wr + PW'(1);
      if (w_resp_fire) r_tag_rd <= r_tag_rd + PW'(1);

      if (i_PC_Src) begin
        // Flush: everything still in flight (minus a response landing now,
        // which is dropped anyway) is stale.
        r_fetch_pc <= {i_Branch_Target[DATA_WIDTH-1:2], 2'b00};
        r_q_rd     <= r_q_wr;
        r_count    <= '0;
        r_discard  <= r_outstanding - CW'(w_resp_fire);
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + DATA_WIDTH'(4);
        if (w_push)     r_q_wr     <= r_q_wr + PW'(1);
        if (w_pop)      r_q_rd     <= r_q_rd + PW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
        if (w_resp_fire && w_drop) r_discard <= r_discard - CW'(1);
      end
    end
  end

  // Storage needs no reset: occupancy and pointers define what is live.
  always_ff @(posedge clk) begin
    if (w_req_fire) r_tag[r_tag_wr] <= r_fetch_pc;
    if (w_push) begin
      r_q_pc[r_q_wr]    <= r_tag[r_tag_rd];
      r_q_instr[r_q_wr] <= i_Mem_Resp_Data;
    end
  end

  // A response with nothing outstanding is a memory protocol error.
  a_no_orphan_resp: assert property (@(posedge clk) disable iff (reset)
    i_Mem_Resp_Valid |-> (r_outstanding != '0));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int unsigned DW  = 32;
  localparam int unsigned QD  = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_PC_Src = 1'b0;
  logic [DW-1:0] i_Branch_Target = '0;
  logic          o_Mem_Req_Valid;
  logic [DW-1:0] o_Mem_Req_Address;
  logic          i_Mem_Req_Ready = 1'b0;
  logic          i_Mem_Resp_Valid = 1'b0;
  logic [DW-1:0] i_Mem_Resp_Data = '0;
  logic          o_Valid;
  logic [DW-1:0] o_Instruction;
  logic [DW-1:0] o_PC;
  logic          i_Ready = 1'b0;

  always #5 clk = ~clk;

  fetch_unit #(.DATA_WIDTH(DW), .RESET_PC(RPC), .QUEUE_DEPTH(QD)) dut (
    .clk(clk), .reset(reset),
    .i_PC_Src(i_PC_Src), .i_Branch_Target(i_Branch_Target),
    .o_Mem_Req_Valid(o_Mem_Req_Valid), .o_Mem_Req_Address(o_Mem_Req_Address),
    .i_Mem_Req_Ready(i_Mem_Req_Ready),
    .i_Mem_Resp_Valid(i_Mem_Resp_Valid), .i_Mem_Resp_Data(i_Mem_Resp_Data),
    .o_Valid(o_Valid), .o_Instruction(o_Instruction), .o_PC(o_PC),
    .i_Ready(i_Ready)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Memory content: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model and memory ----------------
  typedef struct {
    logic [31:0] addr;
    int unsigned epoch;
    int unsigned due;
  } flight_t;

  flight_t     mem_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] pc_m;
  bit          run_m;
  int unsigned inflight, epoch, cyc_n, drops, pops, accepts;
  logic [31:0] last_acc, first_acc, first_pop;
  bit          acc_mark, pop_mark, wrap_seen;

  int unsigned lat_min = 1, lat_max = 1, mreq_pct = 100, dec_pct = 100, redir_pct = 0;
  bit          force_redir = 0, redir_on_resp = 0;
  logic [31:0] force_tgt = '0;

  task automatic do_reset();
    reset = 1'b1;
    i_PC_Src = 0; i_Branch_Target = '0; i_Mem_Req_Ready = 0;
    i_Mem_Resp_Valid = 0; i_Mem_Resp_Data = '0; i_Ready = 0;
    mem_q.delete(); exp_q.delete();
    inflight = 0; run_m = 0; pc_m = RPC; epoch++; last_acc = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance model.
  task automatic step();
    flight_t     r, f;
    bit          rv, src, fire, exp_rv;
    logic [31:0] tgt;
    rv = 0;
    r.addr = '0; r.epoch = 0; r.due = 0;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc_n) begin
      rv = 1;
      r  = mem_q.pop_front();
    end
    i_Mem_Resp_Valid = rv;
    i_Mem_Resp_Data  = rv ? mem_word(r.addr) : $urandom();
    i_Mem_Req_Ready  = ($urandom_range(99) < mreq_pct);
    i_Ready          = ($urandom_range(99) < dec_pct);
    src = force_redir || (redir_on_resp && rv && exp_q.size() != 0 && i_Ready) ||
          (run_m && $urandom_range(99) < redir_pct);
    tgt = force_redir ? force_tgt : $urandom();
    i_PC_Src = src;
    i_Branch_Target = tgt;

    @(negedge clk);
    exp_rv = run_m && !src && (exp_q.size() + inflight < QD);
    chk("req_valid", o_Mem_Req_Valid, exp_rv);
    if (exp_rv) chk("req_addr", o_Mem_Req_Address, pc_m);
    chk("o_valid", o_Valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("o_pc", o_PC, exp_q[0]);
      chk("o_instr", o_Instruction, mem_word(exp_q[0]));
    end

    fire = exp_rv && i_Mem_Req_Ready;
    if (rv) begin
      inflight--;
      if (src || r.epoch != epoch) drops++;
    end
    if (src) begin
      exp_q.delete();
      epoch++;
      pc_m = {tgt[31:2], 2'b00};
    end else begin
      if (exp_q.size() != 0 && i_Ready) begin
        if (!pop_mark) begin first_pop = exp_q[0]; pop_mark = 1; end
        void'(exp_q.pop_front());
        pops++;
      end
      if (rv && r.epoch == epoch) exp_q.push_back(r.addr);
      if (fire) begin
        f.addr = pc_m; f.epoch = epoch; f.due = cyc_n + $urandom_range(lat_max, lat_min);
        mem_q.push_back(f);
        inflight++; accepts++;
        if (!acc_mark) begin first_acc = pc_m; acc_mark = 1; end
        if (pc_m == 32'h0 && last_acc == 32'hFFFF_FFFC) wrap_seen = 1;
        last_acc = pc_m;
        pc_m = pc_m + 32'd4;
      end
    end
    run_m = 1;
    @(posedge clk);
    #1 cyc_n++;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit src; logic [31:0] tgt; bit mrdy; bit rv; logic [31:0] ra; bit rdy;
    bit erq; logic [31:0] era; bit ev; logic [31:0] epc;
  } vec_t;

  function automatic vec_t vec(bit src, logic [31:0] tgt, bit mrdy, bit rv, logic [31:0] ra,
                               bit rdy, bit erq, logic [31:0] era, bit ev, logic [31:0] epc);
    vec_t v;
    v.src = src; v.tgt = tgt; v.mrdy = mrdy; v.rv = rv; v.ra = ra; v.rdy = rdy;
    v.erq = erq; v.era = era; v.ev = ev; v.epc = epc;
    return v;
  endfunction

  vec_t tbl[14];

  initial begin
    int unsigned p0, a0, d0, n, inf0;

    // Startup with 1-cycle memory, then a redirect that lands together with
    // a response and a pop, then decode stalls until credits run out.
    tbl[0]  = vec(0, 0,       1, 0, 0,     1, 0, 0,     0, 0);
    tbl[1]  = vec(0, 0,       1, 0, 0,     1, 1, 0,     0, 0);
    tbl[2]  = vec(0, 0,       1, 1, 0,     1, 1, 'h4,   0, 0);
    tbl[3]  = vec(0, 0,       1, 1, 'h4,   1, 1, 'h8,   1, 0);
    tbl[4]  = vec(0, 0,       1, 1, 'h8,   1, 1, 'hC,   1, 'h4);
    tbl[5]  = vec(1, 'h103,   1, 1, 'hC,   1, 0, 0,     1, 'h8);
    tbl[6]  = vec(0, 0,       1, 0, 0,     1, 1, 'h100, 0, 0);
    tbl[7]  = vec(0, 0,       1, 1, 'h100, 1, 1, 'h104, 0, 0);
    tbl[8]  = vec(0, 0,       1, 1, 'h104, 1, 1, 'h108, 1, 'h100);
    tbl[9]  = vec(0, 0,       1, 1, 'h108, 0, 1, 'h10C, 1, 'h104);
    tbl[10] = vec(0, 0,       1, 1, 'h10C, 0, 1, 'h110, 1, 'h104);
    tbl[11] = vec(0, 0,       1, 0, 0,     0, 0, 0,     1, 'h104);
    tbl[12] = vec(0, 0,       1, 1, 'h110, 1, 0, 0,     1, 'h104);
    tbl[13] = vec(0, 0,       1, 0, 0,     1, 1, 'h114,  1, 'h108);

    reset = 1'b1;
    #2;
    chk("reset_o_valid", o_Valid, 0);
    chk("reset_req_valid", o_Mem_Req_Valid, 0);
    do_reset();

    for (int i = 0; i < 14; i++) begin
      i_PC_Src = tbl[i].src; i_Branch_Target = tbl[i].tgt;
      i_Mem_Req_Ready = tbl[i].mrdy; i_Mem_Resp_Valid = tbl[i].rv;
      i_Mem_Resp_Data = mem_word(tbl[i].ra); i_Ready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("tbl%0d_req_valid", i), o_Mem_Req_Valid, tbl[i].erq);
      if (tbl[i].erq) chk($sformatf("tbl%0d_req_addr", i), o_Mem_Req_Address, tbl[i].era);
      chk($sformatf("tbl%0d_o_valid", i), o_Valid, tbl[i].ev);
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_o_pc", i), o_PC, tbl[i].epc);
        chk($sformatf("tbl%0d_o_instr", i), o_Instruction, mem_word(tbl[i].epc));
      end
      @(posedge clk);
      #1;
    end

    // Sustained throughput: 1-cycle memory, decode always ready.
    do_reset();
    lat_min = 1; lat_max = 1; mreq_pct = 100; dec_pct = 100; redir_pct = 0;
    repeat (10) step();
    p0 = pops;
    repeat (20) step();
    chk("throughput_pops", pops - p0, 20);

    // Decode stalled: exactly QD requests, then resume at 0x10.
    do_reset();
    dec_pct = 0;
    a0 = accepts;
    repeat (20) step();
    chk("stall_accepts", accepts - a0, QD);
    chk("stall_last_addr", last_acc, 32'hC);
    dec_pct = 100; acc_mark = 0;
    repeat (10) step();
    chk("resume_addr", first_acc, 32'h10);

    // Redirect with three requests in flight on a 5-cycle memory.
    do_reset();
    lat_min = 5; lat_max = 5;
    n = 0;
    while (inflight != 3 && n < 20) begin step(); n++; end
    chk("reach_3_outstanding", inflight, 3);
    d0 = drops; force_redir = 1; force_tgt = 32'h103; acc_mark = 0; pop_mark = 0;
    step();
    force_redir = 0;
    repeat (20) step();
    chk("stale_drops", drops - d0, 3);
    chk("redir_first_req", first_acc, 32'h100);
    chk("redir_first_pc", first_pop, 32'h100);

    // Redirect coinciding with a response and a pop.
    do_reset();
    lat_min = 2; lat_max = 2;
    repeat (8) step();
    d0 = drops; n = 0; inf0 = 0;
    redir_on_resp = 1;
    begin
      int unsigned e0;
      e0 = epoch;
      while (epoch == e0 && n < 10) begin inf0 = inflight; step(); n++; end
      chk("redir_on_resp_happened", epoch - e0, 1);
    end
    redir_on_resp = 0;
    chk("redir_flush_o_valid", o_Valid, 0);
    repeat (10) step();
    chk("redir_on_resp_drops", drops - d0, inf0);

    // Fetch PC wraps from 0xFFFF_FFFC to 0.
    do_reset();
    lat_min = 1; lat_max = 3;
    step();
    force_redir = 1; force_tgt = 32'hFFFF_FFF6;
    step();
    force_redir = 0; wrap_seen = 0;
    repeat (12) step();
    chk("pc_wrap", wrap_seen, 1);

    // Random traffic with redirects.
    do_reset();
    lat_min = 1; lat_max = 4; mreq_pct = 60; dec_pct = 70; redir_pct = 3;
    repeat (1500) step();

    // Reset pulse mid-stream with a full queue.
    redir_pct = 0; dec_pct = 0;
    repeat (8) step();
    chk("pre_reset_model_valid", o_Valid, exp_q.size() != 0);
    #2 reset = 1'b1;
    #1;
    chk("midreset_o_valid", o_Valid, 0);
    chk("midreset_req_valid", o_Mem_Req_Valid, 0);
    do_reset();
    dec_pct = 70; mreq_pct = 80; acc_mark = 0;
    repeat (40) step();
    chk("restart_first_req", first_acc, RPC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
